// File: rtl/result_frame_decoder.sv
// Host-side decoder for the AGV transmitData stream: UART receive, frame hunt,
// XOR checksum validation and registered result words.
module result_frame_decoder #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HDR0         = 8'hAA,
  parameter logic [7:0] HDR1         = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serialIn,
  output logic [15:0] max_dist_angle,
  output logic [15:0] min_dist_angle,
  output logic [15:0] obs_alert,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic [7:0]  frame_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT0, P_HUNT1, P_PAYLOAD, P_CHECK} p_state_t;

  logic [1:0]       sync;
  logic             rx_s, rx_d;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             byte_done, stop_bad;

  p_state_t         p_state, p_next;
  logic [2:0]       idx, idx_next;
  logic [7:0]       xsum, xsum_next;
  logic [47:0]      shadow, shadow_next;
  logic             load_out, bad_crc;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= 2'b11;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      sync     <= {sync[0], serialIn};
      rx_d     <= rx_s;
      rx_state <= rx_next;
      rx_cnt   <= cnt_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
    end
  end

  // Sample points land mid-bit: half a bit after the start edge, then every full bit.
  always_comb begin
    rx_next    = rx_state;
    cnt_next   = rx_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_d && !rx_s) begin
          rx_next  = RX_START;
          cnt_next = HALF_LOAD;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rx_s) begin
            rx_next  = RX_DATA;
            cnt_next = BIT_LOAD;
            bit_next = '0;
          end else begin
            rx_next = RX_IDLE;
          end
        end else begin
          cnt_next = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          shift_next = {rx_s, shift[7:1]};
          cnt_next   = BIT_LOAD;
          if (bit_idx == 3'd7) rx_next = RX_STOP;
          else bit_next = bit_idx + 3'd1;
        end else begin
          cnt_next = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_next   = RX_IDLE;
          byte_done = rx_s;
          stop_bad  = !rx_s;
        end else begin
          cnt_next = rx_cnt - 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state <= P_HUNT0;
      idx     <= '0;
      xsum    <= '0;
      shadow  <= '0;
    end else begin
      p_state <= p_next;
      idx     <= idx_next;
      xsum    <= xsum_next;
      shadow  <= shadow_next;
    end
  end

  always_comb begin
    p_next      = p_state;
    idx_next    = idx;
    xsum_next   = xsum;
    shadow_next = shadow;
    load_out    = 1'b0;
    bad_crc     = 1'b0;
    if (stop_bad) begin
      p_next = P_HUNT0;
    end else if (byte_done) begin
      case (p_state)
        P_HUNT0: if (shift == HDR0) p_next = P_HUNT1;
        P_HUNT1: begin
          if (shift == HDR1) begin
            p_next    = P_PAYLOAD;
            idx_next  = '0;
            xsum_next = '0;
          end else if (shift != HDR0) begin
            p_next = P_HUNT0;
          end
        end
        P_PAYLOAD: begin
          // Shifting in MSB-first leaves {max, min, obs} in order after six bytes.
          shadow_next = {shadow[39:0], shift};
          xsum_next   = xsum ^ shift;
          idx_next    = idx + 3'd1;
          if (idx == 3'd5) p_next = P_CHECK;
        end
        P_CHECK: begin
          load_out = (shift == xsum);
          bad_crc  = (shift != xsum);
          p_next   = P_HUNT0;
        end
        default: p_next = P_HUNT0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_dist_angle <= '0;
      min_dist_angle <= '0;
      obs_alert      <= '0;
      frame_valid    <= 1'b0;
      crc_err        <= 1'b0;
      frame_err      <= 1'b0;
      frame_count    <= '0;
    end else begin
      frame_valid <= load_out;
      crc_err     <= bad_crc;
      frame_err   <= stop_bad;
      if (load_out) begin
        {max_dist_angle, min_dist_angle, obs_alert} <= shadow;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/result_frame_decoder.md
# result_frame_decoder

Host-side decoder that consumes the `transmitData` serial stream produced by the AGV distance-processing top level. It recovers UART bytes, locates result frames and validates their XOR checksum. It then presents the latest max-distance angle, min-distance angle and obstacle-alert words as registered outputs with a one-cycle `frame_valid` strobe. It sits directly downstream of the transmitter, on the bench or on a monitoring FPGA, and closes the loop for end-to-end checks.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `HDR0`, 8'hAA: first frame header byte.
- `HDR1`, 8'h55: second frame header byte.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `serialIn`  in  1  UART line, 8N1, idle high, LSB first.
- `max_dist_angle`  out  16  last valid max-distance angle.
- `min_dist_angle`  out  16  last valid min-distance angle.
- `obs_alert`  out  16  last valid obstacle-alert word.
- `frame_valid`  out  1  one-cycle pulse when the three words update.
- `crc_err`  out  1  one-cycle pulse on checksum mismatch.
- `frame_err`  out  1  one-cycle pulse on bad stop bit.
- `frame_count`  out  8  count of valid frames, wraps 255→0.

## Operation
- Frame is 9 bytes: `HDR0`, `HDR1`, max MSB, max LSB, min MSB, min LSB, obs MSB, obs LSB, checksum.
- Checksum = XOR of the 6 payload bytes.
- Input conditioning: `serialIn` passes through a 2-FF synchronizer; both flops reset to 1.
- Receiver FSM:
  - IDLE: a synchronized falling edge moves to START.
  - START: waits `CLKS_PER_BIT/2`, then resamples. Line still low → DATA; line high → IDLE (glitch rejected).
  - DATA: samples every `CLKS_PER_BIT`, 8 bits, LSB first.
  - STOP: samples once more. Sample 1 → one-cycle `byte_done` with the byte. Sample 0 → `frame_err` pulse, byte discarded.
  - STOP returns to IDLE in both cases.
- Parser FSM, advanced only on `byte_done`:
  - HUNT0: byte == `HDR0` → HUNT1; else stay.
  - HUNT1: byte == `HDR1` → PAYLOAD, idx=0, running XOR=0. Byte == `HDR0` → stay in HUNT1 (handles AA AA 55). Anything else → HUNT0.
  - PAYLOAD: stores byte[idx] into the shadow register, XORs it into the running sum, idx++. After idx 5 → CHECK.
  - CHECK: byte == running XOR → copy shadow to outputs, pulse `frame_valid`, increment `frame_count`. Otherwise pulse `crc_err`; outputs hold. Both cases → HUNT0.
- A `frame_err` in any state forces the parser to HUNT0 and discards the partial frame.
- Outputs change only on `frame_valid`; the shadow register is never visible mid-frame.
- Headers are not escaped inside the payload; a payload byte equal to `HDR0` does not resync.

## Timing
- Reset (asynchronous, active-low): everything goes to a known state immediately.
  - All three 16-bit words = 0, `frame_count` = 0, all pulses = 0.
  - Receiver in IDLE, parser in HUNT0, synchronizer = 1.
- Reset asserted mid-byte or mid-frame aborts all state with no partial update.
- After release, the first falling edge is detected normally.
- `byte_done` fires on the cycle the stop bit is sampled: `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the synchronized start edge.
- `frame_valid`, `crc_err` and the new output values appear one cycle after the checksum byte's `byte_done`.
- `frame_err` asserts the cycle after the bad stop-bit sample.
- End-to-end: line edge to synchronized edge = 2 cycles.
- Back-to-back bytes with no idle time are supported; the receiver rearms in IDLE immediately after the STOP sample.
- The pulses are mutually exclusive in any cycle.
- `frame_count` increments only with `frame_valid`.

## Test plan
- Bench `CLKS_PER_BIT=16`. Send AA 55 00 5A 01 0E 00 03 56 → `max_dist_angle`=0x005A, `min_dist_angle`=0x010E, `obs_alert`=0x0003, exactly one `frame_valid` pulse, `frame_count`=1.
- Same frame with checksum 0x57 → one `crc_err` pulse, no `frame_valid`, outputs and `frame_count` unchanged from prior values.
- Send 13 AA AA 55 00 10 00 20 00 01 31 → frame decoded: max=0x0010, min=0x0020, obs=0x0001.
- Drive stop bit low on the 4th payload byte → `frame_err` pulse, no update. An immediately following valid frame decodes correctly.
- Assert `reset` during the 5th payload byte → all outputs 0 immediately. After release, a full valid frame decodes and `frame_count`=1.
- Send 256 valid frames back-to-back with no idle gap → 256 `frame_valid` pulses, `frame_count` wraps to 0.
